// File: rtl/burst_framer_pkg.sv
// burst_framer_pkg
//   Shared definitions for the burst framer: FSM state encoding, default
//   header marker, count width and small helper functions.
//   Optional feature macro: BURST_FRAMER_CHECKSUM_EN adds the TRAILER state.
package burst_framer_pkg;

   localparam int         CNT_W              = 8;
   localparam logic [7:0] HDR_MARKER_DEFAULT = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CAPTURE = 3'd1,
      S_HDR_MK  = 3'd2,
      S_HDR_LEN = 3'd3,
      S_PAYLOAD = 3'd4
`ifdef BURST_FRAMER_CHECKSUM_EN
      , S_TRAILER = 3'd5
`endif
   } state_t;

   // Buffer address width; a one-word buffer still needs a one-bit address.
   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/burst_framer_buf.sv
// burst_buf
//   Simple dual-port buffer: one synchronous write port, one read port with
//   a registered output (rdata shows mem[raddr] one clock after raddr).
//   Ports:
//     clk    in   clock
//     we     in   write enable
//     waddr  in   write address
//     wdata  in   write data (8 bits)
//     raddr  in   read address
//     rdata  out  registered read data (8 bits)
module burst_buf #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/burst_framer.sv
// burst_framer
//   Captures a din_dv-qualified burst of 8-bit words into a local buffer,
//   checks +1 continuity, then replays it as a frame:
//   marker, length, payload[0..count-1] (and a checksum trailer when built
//   with BURST_FRAMER_CHECKSUM_EN) under a valid/ready handshake.
//   Ports:
//     clk            in   clock
//     rst            in   asynchronous active-low reset
//     din_dv, din    in   input word valid / data (no backpressure)
//     dout           out  framed word
//     dout_valid     out  dout valid
//     dout_ready     in   sink accepts dout
//     dout_sof       out  first word of frame (marker)
//     dout_eof       out  last word of frame
//     frame_seq_err  out  continuity error in this frame (marker..EOF)
//     frame_ovf      out  burst exceeded MAX_WORDS (marker..EOF)
//     busy           out  FSM not idle
//     drop_cnt       out  saturating count of words dropped while emitting
//   All outputs are registered.
module burst_framer
   import burst_framer_pkg::*;
#(
   parameter int         MAX_WORDS  = 64,
   parameter logic [7:0] HDR_MARKER = HDR_MARKER_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        din_dv,
   input  logic [7:0]  din,
   output logic [7:0]  dout,
   output logic        dout_valid,
   input  logic        dout_ready,
   output logic        dout_sof,
   output logic        dout_eof,
   output logic        frame_seq_err,
   output logic        frame_ovf,
   output logic        busy,
   output logic [15:0] drop_cnt
);

   localparam int               AW      = addr_w(MAX_WORDS);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] count_reg, count_next;
   // Index of the buffer word that rd_data currently presents.
   logic [CNT_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [7:0]       prev_reg, prev_next;
   logic             seq_err_reg, seq_err_next;
   logic             ovf_reg, ovf_next;
`ifdef BURST_FRAMER_CHECKSUM_EN
   logic [7:0]       xor_reg, xor_next;
`endif

   logic [7:0]       dout_reg, dout_next;
   logic             dout_valid_reg, dout_valid_next;
   logic             dout_sof_reg, dout_sof_next;
   logic             dout_eof_reg, dout_eof_next;
   logic             fseq_reg, fseq_next;
   logic             fovf_reg, fovf_next;
   logic             busy_reg, busy_next;
   logic [15:0]      drop_cnt_reg, drop_cnt_next;

   logic             we;
   logic [AW-1:0]    waddr;
   logic [7:0]       rd_data;
   logic             hs;
   logic             emitting;

   assign hs = dout_valid_reg & dout_ready;

   // Read address follows the next pointer so that rd_data always equals
   // buf[rd_ptr_reg]; this prefetch removes bubbles between payload words.
   burst_buf #(
      .DEPTH (MAX_WORDS),
      .AW    (AW)
   ) u_buf (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (din),
      .raddr (rd_ptr_next[AW-1:0]),
      .rdata (rd_data)
   );

   always_comb begin
      state_next      = state_reg;
      count_next      = count_reg;
      rd_ptr_next     = rd_ptr_reg;
      prev_next       = prev_reg;
      seq_err_next    = seq_err_reg;
      ovf_next        = ovf_reg;
`ifdef BURST_FRAMER_CHECKSUM_EN
      xor_next        = xor_reg;
`endif
      dout_next       = dout_reg;
      dout_valid_next = dout_valid_reg;
      dout_sof_next   = dout_sof_reg;
      dout_eof_next   = dout_eof_reg;
      fseq_next       = fseq_reg;
      fovf_next       = fovf_reg;
      drop_cnt_next   = drop_cnt_reg;
      we              = 1'b0;
      waddr           = count_reg[AW-1:0];
      emitting        = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (din_dv) begin
               we           = 1'b1;
               waddr        = '0;
               count_next   = 8'd1;
               prev_next    = din;
               seq_err_next = 1'b0;
               ovf_next     = 1'b0;
               rd_ptr_next  = '0;
`ifdef BURST_FRAMER_CHECKSUM_EN
               xor_next     = 8'd0;
`endif
               state_next   = S_CAPTURE;
            end
         end

         S_CAPTURE: begin
            if (din_dv) begin
               if (count_reg < MAX_CNT) begin
                  we         = 1'b1;
                  count_next = count_reg + 8'd1;
               end else begin
                  ovf_next = 1'b1;
               end
               // Continuity is checked on every word, stored or dropped.
               if (din != 8'(prev_reg + 8'd1)) begin
                  seq_err_next = 1'b1;
               end
               prev_next = din;
            end else begin
               state_next      = S_HDR_MK;
               dout_next       = HDR_MARKER;
               dout_valid_next = 1'b1;
               dout_sof_next   = 1'b1;
               dout_eof_next   = 1'b0;
               fseq_next       = seq_err_reg;
               fovf_next       = ovf_reg;
            end
         end

         S_HDR_MK: begin
            emitting = 1'b1;
            if (hs) begin
               state_next    = S_HDR_LEN;
               dout_next     = count_reg;
               dout_sof_next = 1'b0;
            end
         end

         S_HDR_LEN: begin
            emitting = 1'b1;
            if (hs) begin
               state_next  = S_PAYLOAD;
               dout_next   = rd_data;
               rd_ptr_next = 8'd1;
`ifdef BURST_FRAMER_CHECKSUM_EN
               dout_eof_next = 1'b0;
`else
               dout_eof_next = (count_reg == 8'd1);
`endif
            end
         end

         S_PAYLOAD: begin
            emitting = 1'b1;
            if (hs) begin
`ifdef BURST_FRAMER_CHECKSUM_EN
               xor_next = xor_reg ^ dout_reg;
`endif
               // rd_ptr_reg == count_reg means the word just accepted was the last.
               if (rd_ptr_reg == count_reg) begin
`ifdef BURST_FRAMER_CHECKSUM_EN
                  state_next    = S_TRAILER;
                  dout_next     = xor_reg ^ dout_reg;
                  dout_eof_next = 1'b1;
`else
                  state_next      = S_IDLE;
                  dout_next       = 8'd0;
                  dout_valid_next = 1'b0;
                  dout_eof_next   = 1'b0;
                  fseq_next       = 1'b0;
                  fovf_next       = 1'b0;
                  rd_ptr_next     = '0;
`endif
               end else begin
                  dout_next   = rd_data;
                  rd_ptr_next = rd_ptr_reg + 8'd1;
`ifdef BURST_FRAMER_CHECKSUM_EN
                  dout_eof_next = 1'b0;
`else
                  dout_eof_next = (8'(rd_ptr_reg + 8'd1) == count_reg);
`endif
               end
            end
         end

`ifdef BURST_FRAMER_CHECKSUM_EN
         S_TRAILER: begin
            emitting = 1'b1;
            if (hs) begin
               state_next      = S_IDLE;
               dout_next       = 8'd0;
               dout_valid_next = 1'b0;
               dout_eof_next   = 1'b0;
               fseq_next       = 1'b0;
               fovf_next       = 1'b0;
               rd_ptr_next     = '0;
            end
         end
`endif

         default: begin
            state_next = S_IDLE;
         end
      endcase

      // Upstream cannot be stalled, so words arriving while a frame is
      // being emitted are counted and discarded.
      if (emitting && din_dv) begin
         drop_cnt_next = sat_inc16(drop_cnt_reg);
      end

      busy_next = (state_next != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= S_IDLE;
         count_reg      <= '0;
         rd_ptr_reg     <= '0;
         prev_reg       <= '0;
         seq_err_reg    <= 1'b0;
         ovf_reg        <= 1'b0;
`ifdef BURST_FRAMER_CHECKSUM_EN
         xor_reg        <= '0;
`endif
         dout_reg       <= '0;
         dout_valid_reg <= 1'b0;
         dout_sof_reg   <= 1'b0;
         dout_eof_reg   <= 1'b0;
         fseq_reg       <= 1'b0;
         fovf_reg       <= 1'b0;
         busy_reg       <= 1'b0;
         drop_cnt_reg   <= '0;
      end else begin
         state_reg      <= state_next;
         count_reg      <= count_next;
         rd_ptr_reg     <= rd_ptr_next;
         prev_reg       <= prev_next;
         seq_err_reg    <= seq_err_next;
         ovf_reg        <= ovf_next;
`ifdef BURST_FRAMER_CHECKSUM_EN
         xor_reg        <= xor_next;
`endif
         dout_reg       <= dout_next;
         dout_valid_reg <= dout_valid_next;
         dout_sof_reg   <= dout_sof_next;
         dout_eof_reg   <= dout_eof_next;
         fseq_reg       <= fseq_next;
         fovf_reg       <= fovf_next;
         busy_reg       <= busy_next;
         drop_cnt_reg   <= drop_cnt_next;
      end
   end

   assign dout          = dout_reg;
   assign dout_valid    = dout_valid_reg;
   assign dout_sof      = dout_sof_reg;
   assign dout_eof      = dout_eof_reg;
   assign frame_seq_err = fseq_reg;
   assign frame_ovf     = fovf_reg;
   assign busy          = busy_reg;
   assign drop_cnt      = drop_cnt_reg;

endmodule

// File: tb/tb_burst_framer.sv
module tb_burst_framer;

   logic        clk;
   logic        rst;
   logic        din_dv;
   logic [7:0]  din;
   logic [7:0]  dout;
   logic        dout_valid;
   logic        dout_ready;
   logic        dout_sof;
   logic        dout_eof;
   logic        frame_seq_err;
   logic        frame_ovf;
   logic        busy;
   logic [15:0] drop_cnt;

   int total = 0;
   int bad   = 0;

   logic [7:0] got_w[$];
   bit         got_sof[$];
   bit         got_eof[$];
   bit         got_seq[$];
   bit         got_ovf[$];
   logic [7:0] exp_w[$];

   typedef struct {
      string name;
      int    start;
      int    n;
      int    gap_pos;
      int    gap;
      int    mode;     // 0: ready always 1, 1: random stalls
      int    exp_len;
      bit    exp_seq;
      bit    exp_ovf;
   } vec_t;

   vec_t vecs[9];

   burst_framer dut (
      .clk           (clk),
      .rst           (rst),
      .din_dv        (din_dv),
      .din           (din),
      .dout          (dout),
      .dout_valid    (dout_valid),
      .dout_ready    (dout_ready),
      .dout_sof      (dout_sof),
      .dout_eof      (dout_eof),
      .frame_seq_err (frame_seq_err),
      .frame_ovf     (frame_ovf),
      .busy          (busy),
      .drop_cnt      (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] word_at(input int start, input int i, input int gp, input int gap);
      int v;
      v = start + i + ((i >= gp) ? gap : 0);
      return v[7:0];
   endfunction

   task automatic send_burst(input int start, input int n, input int gp, input int gap);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         din_dv = 1'b1;
         din    = word_at(start, i, gp, gap);
      end
      @(negedge clk);
      din_dv = 1'b0;
      din    = 8'd0;
   endtask

   // Accept words until EOF; also checks outputs hold steady across stalls.
   task automatic collect(input int mode, output int first_cyc);
      bit         done;
      bit         pending;
      logic [9:0] held;
      got_w.delete(); got_sof.delete(); got_eof.delete();
      got_seq.delete(); got_ovf.delete();
      done = 0; pending = 0; first_cyc = -1; held = '0;
      for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
         @(negedge clk);
         if (pending) begin
            chk("stall_valid", {31'd0, dout_valid}, 32'd1);
            chk("stall_hold", {22'd0, dout_eof, dout_sof, dout}, {22'd0, held});
         end
         dout_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
         if (dout_valid && first_cyc < 0) first_cyc = cyc;
         if (dout_valid && dout_ready) begin
            got_w.push_back(dout);
            got_sof.push_back(dout_sof);
            got_eof.push_back(dout_eof);
            got_seq.push_back(frame_seq_err);
            got_ovf.push_back(frame_ovf);
            pending = 0;
            if (dout_eof) done = 1;
         end else if (dout_valid) begin
            pending = 1;
            held    = {dout_eof, dout_sof, dout};
         end else begin
            pending = 0;
         end
      end
      if (!done) chk("frame_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_frame(input string nm, input int start, input int gp, input int gap,
                              input int exp_len, input bit exp_seq, input bit exp_ovf,
                              input int skip);
      int         nexp;
      int         ng;
      logic [7:0] x;
      logic [9:0] a, e;
      exp_w.delete();
      exp_w.push_back(8'hA5);
      exp_w.push_back(exp_len[7:0]);
      x = 8'd0;
      for (int i = 0; i < exp_len; i++) begin
         exp_w.push_back(word_at(start, i, gp, gap));
         x = x ^ word_at(start, i, gp, gap);
      end
`ifdef BURST_FRAMER_CHECKSUM_EN
      exp_w.push_back(x);
`endif
      nexp = exp_w.size();
      ng   = got_w.size();
      chk($sformatf("%s frame_words", nm), ng, nexp - skip);
      for (int i = 0; i < ng && (i + skip) < nexp; i++) begin
         a = {got_sof[i], got_eof[i], got_w[i]};
         e = {((i + skip) == 0), ((i + skip) == nexp - 1), exp_w[i + skip]};
         chk($sformatf("%s word%0d {sof,eof,data}", nm, i + skip), a, e);
      end
      if (ng > 0) begin
         if (skip == 0) begin
            chk($sformatf("%s seq_err@marker", nm), got_seq[0], exp_seq);
            chk($sformatf("%s ovf@marker", nm), got_ovf[0], exp_ovf);
         end
         chk($sformatf("%s seq_err@eof", nm), got_seq[ng-1], exp_seq);
         chk($sformatf("%s ovf@eof", nm), got_ovf[ng-1], exp_ovf);
      end
      $display("frame %s: words=%0d len=%0d seq_err=%0d ovf=%0d", nm, ng,
               (ng > 1 - skip && skip == 0) ? got_w[1] : exp_len,
               (ng > 0) ? got_seq[ng-1] : 1'b0, (ng > 0) ? got_ovf[ng-1] : 1'b0);
   endtask

   task automatic run_vec(input vec_t v);
      int first;
      send_burst(v.start, v.n, v.gap_pos, v.gap);
      collect(v.mode, first);
      chk($sformatf("%s marker_latency", v.name), first, 0);
      check_frame(v.name, v.start, v.gap_pos, v.gap, v.exp_len, v.exp_seq, v.exp_ovf, 0);
      @(negedge clk);
      chk($sformatf("%s idle_after", v.name), {30'd0, busy, dout_valid}, 32'd0);
   endtask

   initial begin
      int first;
      int vcnt;

      vecs[0] = '{"inc48",    5, 48, 999, 0, 0, 48, 1'b0, 1'b0};
      vecs[1] = '{"jump",     1,  5,   3, 3, 0,  5, 1'b1, 1'b0};
      vecs[2] = '{"ovf70",    0, 70, 999, 0, 0, 64, 1'b0, 1'b1};
      vecs[3] = '{"stall48",  5, 48, 999, 0, 1, 48, 1'b0, 1'b0};
      vecs[4] = '{"single", 200,  1, 999, 0, 0,  1, 1'b0, 1'b0};
      vecs[5] = '{"wrap",   250, 10, 999, 0, 1, 10, 1'b0, 1'b0};
      vecs[6] = '{"full64",   9, 64, 999, 0, 0, 64, 1'b0, 1'b0};
      vecs[7] = '{"ovf65err", 0, 65,  64, 5, 0, 64, 1'b1, 1'b1};
      vecs[8] = '{"earlyjmp",10,  4,   1, 2, 1,  4, 1'b1, 1'b0};

      rst = 1'b0; din_dv = 1'b0; din = 8'd0; dout_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset dout", dout, 0);
      chk("reset flags", {dout_valid, dout_sof, dout_eof, frame_seq_err, frame_ovf, busy}, 0);
      chk("reset drop_cnt", drop_cnt, 0);
      rst = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Burst arriving while the length word is stalled is dropped.
      send_burst(1, 5, 999, 0);
      @(negedge clk);
      dout_ready = 1'b1;
      chk("drop marker", {23'd0, dout_valid, dout}, {23'd0, 1'b1, 8'hA5});
      @(negedge clk);
      dout_ready = 1'b0;
      chk("drop len", {23'd0, dout_valid, dout}, {23'd0, 1'b1, 8'h05});
      send_burst(100, 10, 999, 0);
      chk("drop_cnt after 10", drop_cnt, 10);
      collect(0, first);
      check_frame("after_drop", 1, 999, 0, 5, 1'b0, 1'b0, 1);
      vcnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         vcnt += dout_valid;
      end
      chk("no_second_frame", vcnt, 0);
      chk("drop_cnt stable", drop_cnt, 10);

      // A word on the final-handshake cycle is dropped; IDLE follows.
      send_burst(40, 3, 999, 0);
      collect(0, first);
      din_dv = 1'b1;
      din    = 8'h77;
      @(negedge clk);
      din_dv = 1'b0;
      din    = 8'd0;
      chk("drop on last hs", drop_cnt, 11);
      chk("idle after last hs", busy, 0);
      check_frame("fresh3", 40, 999, 0, 3, 1'b0, 1'b0, 0);

      // Reset in the middle of the payload.
      send_burst(30, 20, 999, 0);
      repeat (6) begin
         @(negedge clk);
         dout_ready = 1'b1;
      end
      chk("mid payload busy", {30'd0, busy, dout_valid}, 32'd3);
      #2 rst = 1'b0;
      #1;
      chk("async rst dout", dout, 0);
      chk("async rst flags", {dout_valid, dout_sof, dout_eof, frame_seq_err, frame_ovf, busy}, 0);
      chk("async rst drop_cnt", drop_cnt, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_vec('{"post_rst", 60, 12, 999, 0, 0, 12, 1'b0, 1'b0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
